// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding plus screen, bird and pipe geometry.
// The render controller imports this too, so bird/pipe geometry has a single source.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Rows are unsigned; columns are signed so a pipe can slide off the left edge.
  localparam logic [9:0]         SCREEN_HEIGHT = 10'd480;
  localparam logic signed [10:0] BIRD_X        = 11'sd303;
  localparam logic signed [10:0] BIRD_WIDTH    = 11'sd34;
  localparam logic [9:0]         BIRD_HEIGHT   = 10'd24;
  localparam logic [9:0]         BIRD_START_Y  = 10'd228;
  localparam logic [9:0]         GROUND_Y      = SCREEN_HEIGHT - BIRD_HEIGHT;
  localparam logic signed [5:0]  GRAVITY       = 6'sd1;
  localparam logic signed [5:0]  FLAP_VELOCITY = -6'sd8;
  localparam logic signed [5:0]  MAX_FALL      = 6'sd10;
  localparam logic signed [10:0] PIPE_WIDTH    = 11'sd52;
  localparam logic [9:0]         PIPE_GAP      = 10'd120;
  localparam logic signed [10:0] PIPE_SPACING  = 11'sd320;
  localparam logic signed [10:0] PIPE_SPEED    = 11'sd2;
  localparam logic signed [10:0] PIPE0_START_X = 11'sd640;
  localparam logic signed [10:0] PIPE1_START_X = 11'sd960;
  localparam logic [9:0]         GAP_RESET_Y   = 10'd192;
  localparam logic [9:0]         GAP_BASE_Y    = 10'd64;
  localparam logic [5:0]         DEATH_FRAMES  = 6'd60;
  localparam logic [15:0]        SCORE_MAX     = 16'd999;
  localparam logic [15:0]        LFSR_SEED     = 16'hACE1;

  function automatic logic [9:0] gap_from_lfsr(input logic [15:0] lfsr);
    return GAP_BASE_Y + {2'b00, lfsr[7:0]};
  endfunction

endpackage

// File: rtl/game_state_controller_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (x^16 + x^14 + x^13 + x^11 + 1), one step per clock.
// Output is the register itself; no enable and no backpressure.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        iClock,
  input  logic        iResetN,
  output logic [15:0] oLfsr
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign oLfsr = r_lfsr;

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) r_lfsr <= SEED;
    else          r_lfsr <= {w_fb, r_lfsr[15:1]};
  end

endmodule

// File: rtl/game_state_controller.sv
// Frame-rate game sequencer: FSM, bird physics, two scrolling pipes, collision and score.
// All outputs are registered and move one cycle after iFrameStart; there is no backpressure.
module game_state_controller
  import game_pkg::*;
(
  input  logic        iClock,
  input  logic        iResetN,
  input  logic        iFrameStart,
  input  logic        iFlap,
  output logic [1:0]  oState,
  output logic [9:0]  oBirdY,
  output logic [15:0] oScore,
  output logic [10:0] oPipe0X,
  output logic [10:0] oPipe1X,
  output logic [9:0]  oPipe0GapY,
  output logic [9:0]  oPipe1GapY,
  output logic        oScrollEn
);

  state_e             r_state, w_state_nxt;
  logic [9:0]         r_bird_y, w_bird_y_nxt;
  logic signed [5:0]  r_vel, w_vel_nxt;
  logic [15:0]        r_score, w_score_nxt;
  logic signed [10:0] r_pipe0_x, r_pipe1_x, w_pipe0_x_nxt, w_pipe1_x_nxt;
  logic [9:0]         r_gap0, r_gap1, w_gap0_nxt, w_gap1_nxt;
  logic [5:0]         r_death_cnt, w_death_cnt_nxt;
  logic               r_flap_d, r_flap_pending, w_flap_pending_nxt;
  logic               r_scroll_en;

  logic [15:0]        w_lfsr;
  logic               w_flap;
  logic signed [5:0]  w_vel_grav;
  logic signed [10:0] w_y_sum;
  logic               w_ground;
  logic [9:0]         w_y_clamp;
  logic signed [10:0] w_p0_step, w_p1_step, w_p0_x, w_p1_x;
  logic               w_p0_wrap, w_p1_wrap;
  logic [9:0]         w_p0_gap, w_p1_gap;
  logic [1:0]         w_cross_cnt;
  logic [15:0]        w_score_sum, w_score_inc;
  logic               w_hit;

  function automatic logic passes_bird(input logic signed [10:0] x_old,
                                       input logic signed [10:0] x_new);
    return (x_old + PIPE_WIDTH >= BIRD_X) && (x_new + PIPE_WIDTH < BIRD_X);
  endfunction

  function automatic logic hits_pipe(input logic signed [10:0] x,
                                     input logic [9:0]         gap,
                                     input logic [9:0]         y);
    logic overlap;
    logic outside;
    overlap = (x < BIRD_X + BIRD_WIDTH) && (x + PIPE_WIDTH > BIRD_X);
    outside = (y < gap) || (y + BIRD_HEIGHT > gap + PIPE_GAP);
    return overlap && outside;
  endfunction

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .iClock  (iClock),
    .iResetN (iResetN),
    .oLfsr   (w_lfsr)
  );

  // A rising edge landing on the tick cycle counts for that tick.
  assign w_flap = r_flap_pending | (iFlap & ~r_flap_d);

  // Position moves by the velocity held before this tick; velocity then updates.
  assign w_vel_grav = (r_vel >= MAX_FALL - GRAVITY) ? MAX_FALL : r_vel + GRAVITY;
  assign w_y_sum    = $signed({1'b0, r_bird_y}) + $signed({{5{r_vel[5]}}, r_vel});
  assign w_ground   = w_y_sum >= $signed({1'b0, GROUND_Y});
  assign w_y_clamp  = w_y_sum[10] ? 10'd0 : (w_ground ? GROUND_Y : w_y_sum[9:0]);

  assign w_p0_step = r_pipe0_x - PIPE_SPEED;
  assign w_p1_step = r_pipe1_x - PIPE_SPEED;
  assign w_p0_wrap = w_p0_step <= -PIPE_WIDTH;
  assign w_p1_wrap = w_p1_step <= -PIPE_WIDTH;
  assign w_p0_x    = w_p0_wrap ? w_p0_step + PIPE_SPACING + PIPE_SPACING : w_p0_step;
  assign w_p1_x    = w_p1_wrap ? w_p1_step + PIPE_SPACING + PIPE_SPACING : w_p1_step;
  assign w_p0_gap  = w_p0_wrap ? gap_from_lfsr(w_lfsr) : r_gap0;
  assign w_p1_gap  = w_p1_wrap ? gap_from_lfsr(w_lfsr) : r_gap1;

  assign w_cross_cnt = {1'b0, passes_bird(r_pipe0_x, w_p0_x)}
                     + {1'b0, passes_bird(r_pipe1_x, w_p1_x)};
  assign w_score_sum = r_score + {14'd0, w_cross_cnt};
  assign w_score_inc = (w_score_sum > SCORE_MAX) ? SCORE_MAX : w_score_sum;

  assign w_hit = hits_pipe(w_p0_x, w_p0_gap, w_y_clamp) || hits_pipe(w_p1_x, w_p1_gap, w_y_clamp);

  always_comb begin
    w_state_nxt        = r_state;
    w_bird_y_nxt       = r_bird_y;
    w_vel_nxt          = r_vel;
    w_score_nxt        = r_score;
    w_pipe0_x_nxt      = r_pipe0_x;
    w_pipe1_x_nxt      = r_pipe1_x;
    w_gap0_nxt         = r_gap0;
    w_gap1_nxt         = r_gap1;
    w_death_cnt_nxt    = r_death_cnt;
    w_flap_pending_nxt = w_flap;
    if (iFrameStart) begin
      w_flap_pending_nxt = 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          w_bird_y_nxt  = BIRD_START_Y;
          w_vel_nxt     = 6'sd0;
          w_pipe0_x_nxt = PIPE0_START_X;
          w_pipe1_x_nxt = PIPE1_START_X;
          if (w_flap) begin
            w_state_nxt = ST_PLAY;
            w_vel_nxt   = FLAP_VELOCITY;
            w_score_nxt = 16'd0;
          end
        end
        ST_PLAY: begin
          w_vel_nxt     = w_flap ? FLAP_VELOCITY : w_vel_grav;
          w_bird_y_nxt  = w_y_clamp;
          w_pipe0_x_nxt = w_p0_x;
          w_pipe1_x_nxt = w_p1_x;
          w_gap0_nxt    = w_p0_gap;
          w_gap1_nxt    = w_p1_gap;
          w_score_nxt   = w_score_inc;
          if (w_ground || w_hit) begin
            w_state_nxt     = ST_DYING;
            w_death_cnt_nxt = 6'd0;
          end
        end
        ST_DYING: begin
          w_vel_nxt    = w_vel_grav;
          w_bird_y_nxt = w_y_clamp;
          if (r_death_cnt == DEATH_FRAMES - 6'd1) begin
            w_state_nxt     = ST_OVER;
            w_death_cnt_nxt = 6'd0;
          end else begin
            w_death_cnt_nxt = r_death_cnt + 6'd1;
          end
        end
        ST_OVER: begin
          if (w_flap) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      r_state        <= ST_IDLE;
      r_bird_y       <= BIRD_START_Y;
      r_vel          <= 6'sd0;
      r_score        <= 16'd0;
      r_pipe0_x      <= PIPE0_START_X;
      r_pipe1_x      <= PIPE1_START_X;
      r_gap0         <= GAP_RESET_Y;
      r_gap1         <= GAP_RESET_Y;
      r_death_cnt    <= 6'd0;
      r_flap_d       <= 1'b0;
      r_flap_pending <= 1'b0;
      r_scroll_en    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_bird_y       <= w_bird_y_nxt;
      r_vel          <= w_vel_nxt;
      r_score        <= w_score_nxt;
      r_pipe0_x      <= w_pipe0_x_nxt;
      r_pipe1_x      <= w_pipe1_x_nxt;
      r_gap0         <= w_gap0_nxt;
      r_gap1         <= w_gap1_nxt;
      r_death_cnt    <= w_death_cnt_nxt;
      r_flap_d       <= iFlap;
      r_flap_pending <= w_flap_pending_nxt;
      r_scroll_en    <= (w_state_nxt == ST_PLAY);
    end
  end

  assign oState     = r_state;
  assign oBirdY     = r_bird_y;
  assign oScore     = r_score;
  assign oPipe0X    = r_pipe0_x;
  assign oPipe1X    = r_pipe1_x;
  assign oPipe0GapY = r_gap0;
  assign oPipe1GapY = r_gap1;
  assign oScrollEn  = r_scroll_en;

endmodule

// File: tb/tb_game_state_controller.sv
// Directed bench for game_state_controller: hand-computed bird, pipe, score and FSM values.
module tb_game_state_controller;

  logic        iClock = 1'b0;
  logic        iResetN, iFrameStart, iFlap;
  logic [1:0]  oState;
  logic [9:0]  oBirdY, oPipe0GapY, oPipe1GapY;
  logic [15:0] oScore;
  logic [10:0] oPipe0X, oPipe1X;
  logic        oScrollEn;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_lfsr, m_tick_lfsr;
  logic [9:0]  exp_gap;

  always #5 iClock = ~iClock;

  game_state_controller dut (
    .iClock     (iClock),
    .iResetN    (iResetN),
    .iFrameStart(iFrameStart),
    .iFlap      (iFlap),
    .oState     (oState),
    .oBirdY     (oBirdY),
    .oScore     (oScore),
    .oPipe0X    (oPipe0X),
    .oPipe1X    (oPipe1X),
    .oPipe0GapY (oPipe0GapY),
    .oPipe1GapY (oPipe1GapY),
    .oScrollEn  (oScrollEn)
  );

  // Reference LFSR: right-shifting Fibonacci form, feedback from bits 0,2,3,5.
  always @(posedge iClock or negedge iResetN) begin
    if (!iResetN) m_lfsr <= 16'hACE1;
    else          m_lfsr <= (m_lfsr >> 1) | {(m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5]), 15'd0};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge iClock);
    iFrameStart = 1'b1;
    m_tick_lfsr = m_lfsr;
    @(negedge iClock);
    iFrameStart = 1'b0;
  endtask

  task automatic flap_tick();
    @(negedge iClock); iFlap = 1'b1;
    @(negedge iClock); iFlap = 1'b0;
    tick();
  endtask

  task automatic flap_tick_now();
    @(negedge iClock);
    iFlap       = 1'b1;
    iFrameStart = 1'b1;
    m_tick_lfsr = m_lfsr;
    @(negedge iClock);
    iFrameStart = 1'b0;
    iFlap       = 1'b0;
  endtask

  initial begin
    iResetN = 1'b0; iFrameStart = 1'b0; iFlap = 1'b0;
    repeat (3) @(negedge iClock);
    chk("rst_state", oState, 0);
    chk("rst_y", oBirdY, 228);
    chk("rst_score", oScore, 0);
    chk("rst_p0x", oPipe0X, 640);
    chk("rst_p1x", oPipe1X, 960);
    chk("rst_gap0", oPipe0GapY, 192);
    chk("rst_gap1", oPipe1GapY, 192);
    chk("rst_scroll", oScrollEn, 0);
    iResetN = 1'b1;

    repeat (10) tick();
    chk("idle_state", oState, 0);
    chk("idle_y", oBirdY, 228);
    chk("idle_p0x", oPipe0X, 640);
    chk("idle_p1x", oPipe1X, 960);
    chk("idle_scroll", oScrollEn, 0);

    // Free fall from a single flap: Y uses the velocity held before each tick.
    flap_tick();
    chk("play_state", oState, 1);
    chk("play_y0", oBirdY, 228);
    chk("play_scroll", oScrollEn, 1);
    tick(); chk("fall_y1", oBirdY, 220);
    tick(); chk("fall_y2", oBirdY, 213);
    tick(); chk("fall_y3", oBirdY, 207);
    chk("fall_p0x3", oPipe0X, 634);
    repeat (15) tick();
    chk("fall_y18", oBirdY, 237);
    tick(); chk("fall_y19", oBirdY, 247);
    tick(); chk("fall_y20_cap", oBirdY, 257);
    repeat (19) tick();
    chk("fall_y39", oBirdY, 447);
    chk("fall_state39", oState, 1);
    tick();
    chk("ground_y", oBirdY, 456);
    chk("ground_state", oState, 2);
    chk("ground_scroll", oScrollEn, 0);
    chk("ground_p0x", oPipe0X, 560);
    chk("ground_p1x", oPipe1X, 880);

    flap_tick();
    repeat (58) tick();
    chk("dying59_state", oState, 2);
    chk("dying59_y", oBirdY, 456);
    chk("dying59_p0x", oPipe0X, 560);
    tick();
    chk("over_state", oState, 3);
    tick();
    chk("over_hold", oState, 3);
    chk("over_score", oScore, 0);
    flap_tick();
    chk("over_to_idle", oState, 0);
    tick();
    chk("idle2_y", oBirdY, 228);
    chk("idle2_p0x", oPipe0X, 640);
    chk("idle2_p1x", oPipe1X, 960);

    // Climb to the ceiling with a flap on every tick.
    flap_tick();
    chk("play2_state", oState, 1);
    repeat (28) flap_tick_now();
    chk("climb_y28", oBirdY, 4);
    flap_tick_now();
    chk("ceil_y", oBirdY, 0);
    chk("ceil_state", oState, 1);
    chk("ceil_p0x", oPipe0X, 582);

    // Pipe0 moved into the bird column while the bird is above the gap.
    @(negedge iClock); force dut.r_pipe0_x = 11'sd300;
    @(negedge iClock); release dut.r_pipe0_x;
    tick();
    chk("hit_state", oState, 2);
    chk("hit_p0x", oPipe0X, 298);
    chk("hit_y", oBirdY, 0);
    tick();
    chk("frozen_p0x", oPipe0X, 298);
    chk("frozen_p1x", oPipe1X, 900);
    repeat (3) @(negedge iClock);
    chk("between_p0x", oPipe0X, 298);

    @(negedge iClock); iResetN = 1'b0;
    #1;
    chk("arst_state", oState, 0);
    chk("arst_y", oBirdY, 228);
    chk("arst_p0x", oPipe0X, 640);
    repeat (2) @(negedge iClock);
    iResetN = 1'b1;

    flap_tick();
    chk("play3_state", oState, 1);
    @(negedge iClock); force dut.r_pipe0_x = 11'sd252;
    @(negedge iClock); release dut.r_pipe0_x;
    tick();
    chk("pass_p0x", oPipe0X, 250);
    chk("pass_score", oScore, 1);
    chk("pass_state", oState, 1);
    tick();
    chk("pass_once", oScore, 1);

    @(negedge iClock); force dut.r_pipe0_x = -11'sd50;
    @(negedge iClock); release dut.r_pipe0_x;
    tick();
    exp_gap = 10'd64 + {2'b00, m_tick_lfsr[7:0]};
    chk("wrap_p0x", oPipe0X, 588);
    chk("wrap_gap0", oPipe0GapY, exp_gap);
    chk("wrap_gap1", oPipe1GapY, 192);
    chk("wrap_score", oScore, 1);

    @(negedge iClock);
    force dut.r_score   = 16'd999;
    force dut.r_pipe0_x = 11'sd252;
    @(negedge iClock);
    release dut.r_score;
    release dut.r_pipe0_x;
    tick();
    chk("sat_score", oScore, 999);
    chk("sat_p0x", oPipe0X, 250);

    @(negedge iClock);
    force dut.r_score   = 16'd5;
    force dut.r_pipe0_x = 11'sd252;
    force dut.r_pipe1_x = 11'sd252;
    @(negedge iClock);
    release dut.r_score;
    release dut.r_pipe0_x;
    release dut.r_pipe1_x;
    tick();
    chk("dual_score", oScore, 7);
    chk("dual_p1x", oPipe1X, 250);
    chk("dual_state", oState, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_state_controller.md
# game_state_controller

Frame-rate game sequencer for the Flappy-style display. It runs the game state machine, bird vertical physics, two scrolling pipes with pseudo-random gaps, collision detection and the score counter. Its registered outputs drive the render controller's bird-Y, score, pipe and scroll inputs, so the renderer stays a pure pixel datapath. All state advances once per frame, on the frame-start pulse from the video timing block.

## Interface
- SCREEN_HEIGHT, 480, visible lines
- BIRD_X, 303, bird left column (320 - 34/2)
- BIRD_WIDTH, 34, bird width in pixels
- BIRD_HEIGHT, 24, bird height in pixels
- BIRD_START_Y, 228, bird Y in IDLE
- GRAVITY, 1, velocity increment per frame (px)
- FLAP_VELOCITY, -8, signed velocity loaded on flap
- MAX_FALL, 10, terminal velocity (px/frame)
- PIPE_WIDTH, 52, pipe width in pixels
- PIPE_GAP, 120, vertical gap height
- PIPE_SPACING, 320, horizontal distance between pipes
- PIPE_SPEED, 2, pipe scroll per frame (px)
- DEATH_FRAMES, 60, frames spent in DYING
- iClock  in  1  system clock
- iResetN  in  1  reset; one clock, asynchronous, active-low
- iFrameStart  in  1  one-cycle pulse per frame
- iFlap  in  1  flap button level, already synchronised to iClock
- oState  out  2  0 IDLE, 1 PLAY, 2 DYING, 3 OVER
- oBirdY  out  10  bird top row
- oScore  out  16  score, saturates at 999
- oPipe0X, oPipe1X  out  11  signed two's-complement pipe left column
- oPipe0GapY, oPipe1GapY  out  10  gap top row
- oScrollEn  out  1  background scroll enable; high only in PLAY

## Operation
- Flap: the rising edge of iFlap sets sticky flap_pending. A frame tick consumes and clears it. An edge in the same cycle as iFrameStart counts for that tick.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Reset seed 16'hACE1. Steps every clock. New gap = 64 + lfsr[7:0], giving a range of 64..319.
- IDLE, each tick:
  - bird Y = BIRD_START_Y, velocity 0.
  - pipe0 X = 640, pipe1 X = 960; gaps hold.
  - flap_pending → PLAY, velocity = FLAP_VELOCITY, score = 0.
- PLAY, each tick:
  - Velocity: FLAP_VELOCITY if flap_pending, else min(v + GRAVITY, MAX_FALL).
  - Bird Y: y' = y + v. If y' < 0, clamp to 0; the ceiling is not fatal.
  - Ground: if y' ≥ SCREEN_HEIGHT - BIRD_HEIGHT (456), clamp to 456 → DYING.
  - Pipes: each X -= PIPE_SPEED. If the new X ≤ -PIPE_WIDTH, X += 2·PIPE_SPACING and gap reloads from the LFSR.
  - Score: +1 (saturating at 999) when a pipe's right edge (X + PIPE_WIDTH) goes from ≥ BIRD_X to < BIRD_X. Both pipes crossing on the same tick adds 2.
  - Collision, evaluated on updated values:
    - horizontal overlap when X < BIRD_X + BIRD_WIDTH and X + PIPE_WIDTH > BIRD_X;
    - vertical hit when y < gap or y + BIRD_HEIGHT > gap + PIPE_GAP.
    - Horizontal overlap plus vertical hit → DYING.
  - Ground and pipe hit on the same tick → DYING, once.
- DYING:
  - Pipes frozen, flap ignored.
  - Bird keeps falling under gravity, clamped at 456.
  - Frame counter counts DEATH_FRAMES ticks → OVER.
- OVER: all outputs hold; flap_pending → IDLE. Score stays visible until the next PLAY entry.
- Signed arithmetic: velocity 6-bit signed, intermediate Y 11-bit signed, pipe X 11-bit signed.

## Timing
- All outputs registered.
- Reset values: oState = IDLE, oBirdY = 228, oScore = 0, oPipe0X = 640, oPipe1X = 960, both gaps = 192, oScrollEn = 0. flap_pending = 0, velocity 0, death counter 0.
- Outputs update in the cycle after iFrameStart is sampled high and are stable for the rest of the frame.
- Between ticks, nothing changes except the LFSR and flap_pending.
- iResetN low mid-frame returns to reset values immediately, asynchronously. Release is sampled on iClock.
- iFrameStart pulses on consecutive cycles are each treated as a full tick.

## Structure
- Package game_pkg holds:
  - the state encoding (IDLE/PLAY/DYING/OVER);
  - the screen, bird and pipe geometry constants, shared with the render controller so bird/pipe geometry has one source.
- Sub-module lfsr16: free-running LFSR with seed parameter and 16-bit output.
- Everything else (FSM, physics, pipes, score) lives in one module.

## Test plan
- Reset, no stimulus, 10 ticks → all outputs at reset values, oState = 0.
- IDLE flap then no input → PLAY; per-tick bird Y = 228, 220, 213, 207, …; velocity capped at +10.
- Free fall from PLAY → oBirdY clamps at 456, DYING on that tick. oState = 3 exactly 60 ticks later; flap → IDLE.
- Pipe0 forced to wrap (X 640 → ≤ -52) → X becomes X + 640, gap = 64 + lfsr[7:0]. Score increments once when pipe0 right edge passes 303.
- Bird at Y = 30 with pipe gap 192 and overlapping X → DYING on that tick, pipes frozen afterwards.
- Score preloaded to 999, pipe passes → oScore stays 999.
